// File: rtl/led_frame_buffer_ctrl.sv
// Double-buffered RGB frame store for the 32x16 LED matrix scan driver.
// Game logic writes the back bank; the scan driver reads pixel pairs from the front bank.
module led_frame_buffer_ctrl #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 16,
  parameter int CW     = 3,
  parameter int XW     = 5,
  parameter int YW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [CW-1:0] wr_rgb,
  input  logic          clr_req,
  input  logic          swap_req,
  input  logic          frame_done,
  input  logic [YW-2:0] rd_row,
  input  logic [XW-1:0] rd_col,
  output logic [CW-1:0] rgb_top,
  output logic [CW-1:0] rgb_bot,
  output logic          busy,
  output logic          swap_ack,
  output logic          front_sel
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int LW   = $clog2(NPIX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  logic [CW-1:0] mem_q [2][NPIX];

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          lat_q, lat_d;
  logic          front_q, front_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          blk_q, blk_d;
  logic [CW-1:0] top_q, bot_q;

  logic          swap_eff;
  logic          wr_ok;
  logic [LW-1:0] lin_w, lin_top, lin_bot;

  // A swap_req still held from the previous swap must drop before it counts again.
  assign swap_eff = swap_req && !blk_q;

  assign lin_w   = LW'(wr_y) * LW'(WIDTH) + LW'(wr_x);
  assign lin_top = LW'(rd_row) * LW'(WIDTH) + LW'(rd_col);
  assign lin_bot = lin_top + LW'(NPIX / 2);

  assign wr_ok = wr_en && (state_q != ST_CLEAR) &&
                 (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    front_d = front_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    blk_d   = blk_q && swap_req;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
          lat_d   = swap_eff;
        end else if (swap_eff) begin
          state_d = ST_SWAP;
        end
      end
      ST_CLEAR: begin
        if (swap_eff) lat_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LW'(NPIX - 1)) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = (lat_q || swap_eff) ? ST_SWAP : ST_IDLE;
        end
      end
      ST_SWAP: begin
        if (frame_done) begin
          front_d = !front_q;
          lat_d   = 1'b0;
          ack_d   = 1'b1;
          blk_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= 1'b0;
      front_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      blk_q   <= 1'b0;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      front_q <= front_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      blk_q   <= blk_d;
      top_q   <= mem_q[front_q][lin_top];
      bot_q   <= mem_q[front_q][lin_bot];
    end
  end

  // Storage is deliberately unreset; the clear walks the back bank one pixel per cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[!front_q][cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[!front_q][lin_w] <= wr_rgb;
    end
  end

  assign rgb_top   = top_q;
  assign rgb_bot   = bot_q;
  assign busy      = busy_q;
  assign swap_ack  = ack_q;
  assign front_sel = front_q;

endmodule

// File: tb/tb_led_frame_buffer_ctrl.sv
// Directed self-checking bench for led_frame_buffer_ctrl.
module tb_led_frame_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_x;
  logic [3:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clr_req;
  logic       swap_req;
  logic       frame_done;
  logic [2:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rgb_top;
  logic [2:0] rgb_bot;
  logic       busy;
  logic       swap_ack;
  logic       front_sel;

  int checks = 0;
  int errors = 0;
  int n;
  int acks;

  always #5 clk = !clk;

  led_frame_buffer_ctrl #(.WIDTH(32), .HEIGHT(16), .CW(3), .XW(5), .YW(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clr_req(clr_req), .swap_req(swap_req), .frame_done(frame_done),
    .rd_row(rd_row), .rd_col(rd_col), .rgb_top(rgb_top), .rgb_bot(rgb_bot),
    .busy(busy), .swap_ack(swap_ack), .front_sel(front_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] rgb);
    wr_en = 1'b1; wr_x = 5'(x); wr_y = 4'(y); wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int row, input int col);
    rd_row = 3'(row); rd_col = 5'(col);
    tick();
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clr_req = 1'b0; swap_req = 1'b0; frame_done = 1'b0; rd_row = '0; rd_col = '0;
    repeat (3) tick();
    check("rst_front", 32'(front_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(swap_ack), 0);
    check("rst_top", 32'(rgb_top), 0);
    check("rst_bot", 32'(rgb_bot), 0);
    reset = 1'b0;
    tick();

    // Clear bank 1: busy for exactly 512 cycles
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
    check("clr_busy_len", 32'(n), 512);
    check("clr_front", 32'(front_sel), 0);

    // Write two pixels into bank 1, then swap
    wr(5, 2, 3'b100);
    wr(5, 10, 3'b010);
    swap_req = 1'b1;
    repeat (20) tick();
    check("pend_front", 32'(front_sel), 0);
    check("pend_ack", 32'(swap_ack), 0);
    pulse_fd();
    check("swap1_ack", 32'(swap_ack), 1);
    check("swap1_front", 32'(front_sel), 1);
    tick();
    check("swap1_ack_off", 32'(swap_ack), 0);
    // Held swap_req is not a fresh request
    repeat (3) tick();
    pulse_fd();
    tick();
    check("held_no_swap", 32'(front_sel), 1);
    swap_req = 1'b0;
    rd(2, 5);
    check("rd_top_100", 32'(rgb_top), 32'h4);
    check("rd_bot_010", 32'(rgb_bot), 32'h2);
    rd(0, 0);
    check("rd_cleared", 32'(rgb_top), 0);

    // Long pending swap with no frame_done; writes to bank 0 still land
    wr(3, 1, 3'b011);
    swap_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        wr_en = 1'b1; wr_x = 5'd7; wr_y = 4'd9; wr_rgb = 3'b101;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (swap_ack) acks++;
    end
    check("long_acks", 32'(acks), 0);
    check("long_front", 32'(front_sel), 1);
    pulse_fd();
    swap_req = 1'b0;
    check("long_ack", 32'(swap_ack), 1);
    check("long_front_sw", 32'(front_sel), 0);
    rd(1, 3);
    check("long_rd_top", 32'(rgb_top), 32'h3);
    rd(1, 7);
    check("long_rd_bot", 32'(rgb_bot), 32'h5);

    // clr_req+swap_req together: swap waits for the clear, ignored writes/clr
    clr_req = 1'b1; swap_req = 1'b1;
    tick();
    clr_req = 1'b0; swap_req = 1'b0;
    n = 0;
    for (int i = 1; i < 600; i++) begin
      wr_en = (i == 50);
      wr_x = '0; wr_y = '0; wr_rgb = 3'b111;
      clr_req = (i == 300);
      frame_done = (i == 100);
      if (busy) n++;
      tick();
      if (i == 100) check("cs_no_swap100", 32'(front_sel), 0);
    end
    wr_en = 1'b0; clr_req = 1'b0; frame_done = 1'b0;
    check("cs_busy_len", 32'(n), 512);
    check("cs_front_pre", 32'(front_sel), 0);
    pulse_fd();
    check("cs_ack", 32'(swap_ack), 1);
    check("cs_front", 32'(front_sel), 1);
    rd(0, 0);
    check("cs_rd00", 32'(rgb_top), 0);
    rd(2, 5);
    check("cs_rd_top", 32'(rgb_top), 0);
    check("cs_rd_bot", 32'(rgb_bot), 0);

    // Reset mid-clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (200) tick();
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_front", 32'(front_sel), 0);
    tick();
    reset = 1'b0;
    tick();
    swap_req = 1'b1;
    repeat (5) tick();
    swap_req = 1'b0;
    repeat (5) tick();
    check("mrst_pend_front", 32'(front_sel), 0);
    pulse_fd();
    check("mrst_ack", 32'(swap_ack), 1);
    check("mrst_front_sw", 32'(front_sel), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
